// File: rtl/sevenseg_pkg.sv
// Shared constants, state type and the hex glyph table for the 7-segment scan driver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sevenseg_pkg;

    // All segments off (active-low pins).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Glyph table, segments a..g with a as the MSB, active-low; entry k sits at index k.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    // ST_START is the single cycle after reset release that opens the first frame.
    typedef enum logic {
        ST_START = 1'b0,
        ST_SCAN  = 1'b1
    } scan_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Bundle between the bus monitor (source buses, display settings) and the display pins.
// Latency: n/a (wires only).
// Backpressure: none; the display side samples whatever is presented at frame start.
interface sevenseg_scan_driver_if #(
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_SOURCES = 3,
    parameter int SEL_W       = 2
);
    import sevenseg_pkg::*;

    logic [32*NUM_SOURCES-1:0] src_data;
    logic [SEL_W-1:0]          src_sel;
    logic                      blank_lz;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic [3:0]                brightness;
    logic [NUM_DIGITS-1:0]     enable;
    logic [6:0]                LED_out;
    logic                      dp_out;
    logic                      frame_tick;

    // Bus-monitor side: supplies the values and settings, observes the frame pulse.
    modport master (
        output src_data, src_sel, blank_lz, dp_mask, brightness,
        input  enable, LED_out, dp_out, frame_tick
    );

    // Display driver side.
    modport slave (
        input  src_data, src_sel, blank_lz, dp_mask, brightness,
        output enable, LED_out, dp_out, frame_tick
    );

endinterface

// File: rtl/sevenseg_decoder.sv
// Combinational hex nibble to active-low 7-segment glyph.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module sevenseg_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed hex display driver: frame snapshot, digit scan, leading-zero blanking, DP, PWM.
// Latency: pins are registered, 1 cycle after the prescaler/index state that produces them.
// Backpressure: none; inputs are sampled only at frame start, changes mid-frame are ignored.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_SOURCES = 3,
    parameter int SEL_W       = 2,
    parameter int REFRESH_DIV = 400000,
    parameter int CNT_W       = 21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sevenseg_scan_driver_if.slave bus
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SNAP_W = 4 * NUM_DIGITS;
    localparam int PROD_W = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [SNAP_W-1:0]     snap_q;
    logic                  blank_lz_q;
    logic [NUM_DIGITS-1:0] dp_mask_q;
    logic [CNT_W-1:0]      on_len_q;

    logic                  slot_end;
    logic                  frame_start;
    logic [SNAP_W-1:0]     sel_bits;
    logic                  sel_ok;
    logic [PROD_W-1:0]     on_prod;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic                  cur_dp;
    logic [NUM_DIGITS-1:0] cur_en;
    logic [6:0]            cur_seg;

    logic [NUM_DIGITS-1:0] enable_q;
    logic [6:0]            led_q;
    logic                  dp_q;
    logic                  tick_q;

    assign slot_end = (state_q == ST_SCAN) && (cnt_q == CNT_LAST);

    // State register: ST_START lasts exactly one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and frame-start decode: first cycle after reset, or the slot end that wraps the index.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        case (state_q)
            ST_START: begin
                state_d     = ST_SCAN;
                frame_start = 1'b1;
            end
            ST_SCAN: begin
                frame_start = slot_end && (idx_q == IDX_LAST);
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // Prescaler and digit index; both hold at zero during the start cycle so digit 0 gets a full slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (state_q == ST_SCAN) begin
            if (slot_end) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Source mux; an out-of-range select is flagged so the snapshot keeps its old value.
    always_comb begin
        sel_bits = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (bus.src_sel == SEL_W'(k)) begin
                sel_bits = bus.src_data[32*k +: SNAP_W];
                sel_ok   = 1'b1;
            end
        end
        on_prod = (PROD_W'(bus.brightness) + PROD_W'(1)) * PROD_W'(REFRESH_DIV);
    end

    // Frame-coherent capture of the value and all display settings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q     <= '0;
            blank_lz_q <= 1'b0;
            dp_mask_q  <= '0;
            on_len_q   <= '0;
        end else if (frame_start) begin
            if (sel_ok) begin
                snap_q <= sel_bits;
            end
            blank_lz_q <= bus.blank_lz;
            dp_mask_q  <= bus.dp_mask;
            on_len_q   <= CNT_W'(on_prod >> 4);
        end
    end

    // Leading-zero mask: digit i blanks when it and every higher nibble are zero; digit 0 never blanks.
    always_comb begin
        lz_mask  = '0;
        zero_run = blank_lz_q;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (snap_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    // Per-slot selection of nibble, blank flag, DP and the PWM-gated anode pattern.
    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        cur_en    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = snap_q[4*i +: 4];
                cur_blank = lz_mask[i];
                cur_dp    = dp_mask_q[i];
                cur_en[i] = !(cnt_q < on_len_q);
            end
        end
    end

    sevenseg_decoder u_decoder (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    // Registered pins; dark during the start cycle and for blanked digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= '1;
            led_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= frame_start;
            if ((state_q == ST_START) || cur_blank) begin
                enable_q <= '1;
                led_q    <= SEG_BLANK;
                dp_q     <= 1'b1;
            end else begin
                enable_q <= cur_en;
                led_q    <= cur_seg;
                dp_q     <= ~cur_dp;
            end
        end
    end

    assign bus.enable     = enable_q;
    assign bus.LED_out    = led_q;
    assign bus.dp_out     = dp_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with 4 digits, 3 sources and a 16-cycle slot.
// Latency: frame_tick one cycle after release, digit 0 on the cycle after that.
// Backpressure: n/a.
module tb_sevenseg_scan_driver;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] G6 = 7'b0100000;
    localparam logic [6:0] G7 = 7'b0001111;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b1100000;
    localparam logic [6:0] GC = 7'b0110001;
    localparam logic [6:0] GD = 7'b1000010;
    localparam logic [6:0] BL = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sevenseg_scan_driver_if #(.NUM_DIGITS(4), .NUM_SOURCES(3), .SEL_W(2)) bus ();

    sevenseg_scan_driver #(
        .NUM_DIGITS  (4),
        .NUM_SOURCES (3),
        .SEL_W       (2),
        .REFRESH_DIV (16),
        .CNT_W       (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observations of one frame, filled by capture_frame.
    int         on_cnt  [4];
    logic [6:0] led_obs [4];
    logic       dp_obs  [4];
    int         bad_en;
    int         bad_ft;
    logic       ft_end;

    // Expectations set by each test.
    logic [6:0] exp_led [4];
    int         exp_on  [4];
    logic       exp_dp  [4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starting at a frame_tick sample, record 64 cycles; ends on the next frame_tick sample.
    task automatic capture_frame(input int change_at, input logic [95:0] new_src);
        logic [3:0] want_low;
        bad_en = 0;
        bad_ft = 0;
        for (int d = 0; d < 4; d++) begin
            on_cnt[d] = 0;
            want_low = 4'b1111;
            want_low[d] = 1'b0;
            for (int j = 0; j < 16; j++) begin
                if (d * 16 + j == change_at) bus.src_data = new_src;
                tick;
                if (j == 0) begin
                    led_obs[d] = bus.LED_out;
                    dp_obs[d]  = bus.dp_out;
                end
                if (bus.enable == want_low) on_cnt[d]++;
                else if (bus.enable != 4'b1111) bad_en++;
                if (bus.frame_tick && !(d == 3 && j == 15)) bad_ft++;
            end
        end
        ft_end = bus.frame_tick;
    endtask

    task automatic test_reset;
        bus.src_data   = {32'h0000_0040, 32'h0000_ABCD, 32'h0000_1234};
        bus.src_sel    = 2'd0;
        bus.blank_lz   = 1'b0;
        bus.dp_mask    = 4'b0000;
        bus.brightness = 4'd15;
        rst_n = 1'b0;
        tick;
        tick;
        n_checks++; if (bus.enable !== 4'b1111) $display("FAIL reset_enable got=%b want=1111", bus.enable); else n_pass++;
        n_checks++; if (bus.LED_out !== BL) $display("FAIL reset_led got=%b want=%b", bus.LED_out, BL); else n_pass++;
        n_checks++; if (bus.dp_out !== 1'b1) $display("FAIL reset_dp got=%b want=1", bus.dp_out); else n_pass++;
        n_checks++; if (bus.frame_tick !== 1'b0) $display("FAIL reset_tick got=%b want=0", bus.frame_tick); else n_pass++;
        rst_n = 1'b1;
        tick;
        n_checks++; if (bus.frame_tick !== 1'b1) $display("FAIL first_tick got=%b want=1", bus.frame_tick); else n_pass++;
        n_checks++; if (bus.enable !== 4'b1111) $display("FAIL first_cycle_enable got=%b want=1111", bus.enable); else n_pass++;
    endtask

    task automatic test_scan;
        exp_led = '{G4, G3, G2, G1};
        capture_frame(-1, '0);
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (led_obs[d] !== exp_led[d]) $display("FAIL scan_led d%0d got=%b want=%b", d, led_obs[d], exp_led[d]); else n_pass++;
            n_checks++; if (on_cnt[d] != 16) $display("FAIL scan_on d%0d got=%0d want=16", d, on_cnt[d]); else n_pass++;
            n_checks++; if (dp_obs[d] !== 1'b1) $display("FAIL scan_dp d%0d got=%b want=1", d, dp_obs[d]); else n_pass++;
        end
        n_checks++; if (bad_en != 0) $display("FAIL scan_bad_enable got=%0d want=0", bad_en); else n_pass++;
        n_checks++; if (bad_ft != 0) $display("FAIL scan_stray_tick got=%0d want=0", bad_ft); else n_pass++;
        n_checks++; if (ft_end !== 1'b1) $display("FAIL scan_frame_period got=%b want=1", ft_end); else n_pass++;
    endtask

    task automatic test_coherent;
        bus.src_sel = 2'd1;
        capture_frame(-1, '0);
        n_checks++; if (led_obs[0] !== G4) $display("FAIL sel_not_midframe got=%b want=%b", led_obs[0], G4); else n_pass++;
        exp_led = '{GD, GC, GB, GA};
        capture_frame(24, {32'h0000_0040, 32'h0000_5678, 32'h0000_1234});
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (led_obs[d] !== exp_led[d]) $display("FAIL coherent_led d%0d got=%b want=%b", d, led_obs[d], exp_led[d]); else n_pass++;
        end
        exp_led = '{G8, G7, G6, G5};
        capture_frame(-1, '0);
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (led_obs[d] !== exp_led[d]) $display("FAIL next_frame_led d%0d got=%b want=%b", d, led_obs[d], exp_led[d]); else n_pass++;
        end
    endtask

    task automatic test_blank;
        bus.src_sel  = 2'd2;
        bus.blank_lz = 1'b1;
        capture_frame(-1, '0);
        exp_led = '{G0, G4, BL, BL};
        exp_on  = '{16, 16, 0, 0};
        capture_frame(-1, '0);
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (led_obs[d] !== exp_led[d]) $display("FAIL lz_led d%0d got=%b want=%b", d, led_obs[d], exp_led[d]); else n_pass++;
            n_checks++; if (on_cnt[d] != exp_on[d]) $display("FAIL lz_on d%0d got=%0d want=%0d", d, on_cnt[d], exp_on[d]); else n_pass++;
        end
        n_checks++; if (dp_obs[3] !== 1'b1) $display("FAIL lz_dp got=%b want=1", dp_obs[3]); else n_pass++;
        bus.src_data[95:64] = 32'h0;
        capture_frame(-1, '0);
        exp_led = '{G0, BL, BL, BL};
        exp_on  = '{16, 0, 0, 0};
        capture_frame(-1, '0);
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (led_obs[d] !== exp_led[d]) $display("FAIL zero_led d%0d got=%b want=%b", d, led_obs[d], exp_led[d]); else n_pass++;
            n_checks++; if (on_cnt[d] != exp_on[d]) $display("FAIL zero_on d%0d got=%0d want=%0d", d, on_cnt[d], exp_on[d]); else n_pass++;
        end
    endtask

    task automatic test_pwm;
        bus.src_sel    = 2'd0;
        bus.blank_lz   = 1'b0;
        bus.brightness = 4'd3;
        capture_frame(-1, '0);
        capture_frame(-1, '0);
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (on_cnt[d] != 4) $display("FAIL pwm3_on d%0d got=%0d want=4", d, on_cnt[d]); else n_pass++;
        end
        n_checks++; if (led_obs[0] !== G4) $display("FAIL pwm3_led got=%b want=%b", led_obs[0], G4); else n_pass++;
        n_checks++; if (bad_en != 0) $display("FAIL pwm3_bad_enable got=%0d want=0", bad_en); else n_pass++;
        bus.brightness = 4'd0;
        capture_frame(-1, '0);
        capture_frame(-1, '0);
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (on_cnt[d] != 1) $display("FAIL pwm0_on d%0d got=%0d want=1", d, on_cnt[d]); else n_pass++;
        end
    endtask

    task automatic test_dp_and_sel;
        bus.brightness = 4'd15;
        bus.dp_mask    = 4'b0100;
        capture_frame(-1, '0);
        exp_dp = '{1'b1, 1'b1, 1'b0, 1'b1};
        capture_frame(-1, '0);
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (dp_obs[d] !== exp_dp[d]) $display("FAIL dp d%0d got=%b want=%b", d, dp_obs[d], exp_dp[d]); else n_pass++;
        end
        bus.src_sel = 2'd3;
        bus.src_data[31:0] = 32'h0000_9999;
        capture_frame(-1, '0);
        exp_led = '{G4, G3, G2, G1};
        capture_frame(-1, '0);
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (led_obs[d] !== exp_led[d]) $display("FAIL sel_oob_hold d%0d got=%b want=%b", d, led_obs[d], exp_led[d]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        bus.src_sel = 2'd1;
        bus.dp_mask = 4'b0001;
        for (int i = 0; i < 5; i++) tick;
        n_checks++; if (bus.enable !== 4'b1110) $display("FAIL pre_reset_enable got=%b want=1110", bus.enable); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.enable !== 4'b1111) $display("FAIL async_enable got=%b want=1111", bus.enable); else n_pass++;
        n_checks++; if (bus.LED_out !== BL) $display("FAIL async_led got=%b want=%b", bus.LED_out, BL); else n_pass++;
        n_checks++; if (bus.dp_out !== 1'b1) $display("FAIL async_dp got=%b want=1", bus.dp_out); else n_pass++;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        n_checks++; if (bus.frame_tick !== 1'b1) $display("FAIL restart_tick got=%b want=1", bus.frame_tick); else n_pass++;
        exp_led = '{G8, G7, G6, G5};
        capture_frame(-1, '0);
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (led_obs[d] !== exp_led[d]) $display("FAIL restart_led d%0d got=%b want=%b", d, led_obs[d], exp_led[d]); else n_pass++;
        end
        n_checks++; if (on_cnt[0] != 16) $display("FAIL restart_digit0 got=%0d want=16", on_cnt[0]); else n_pass++;
        n_checks++; if (dp_obs[0] !== 1'b0) $display("FAIL restart_dp got=%b want=0", dp_obs[0]); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_scan;
        test_coherent;
        test_blank;
        test_pwm;
        test_dp_and_sel;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
